// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one memory port between the core MEM stage
// and a debug/loader requester, with one outstanding access and fixed read latency.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wr_data,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rd_data,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic [15:0]       stall_cnt
);

    localparam int LAT_W = 3;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LAT_W-1:0]  r_lat;
    logic [LAT_W-1:0]  w_lat_nxt;
    logic              r_owner_dbg;
    logic              w_owner_nxt;
    logic              r_last_dbg;
    logic              w_last_nxt;
    logic [15:0]       r_stall_cnt;

    logic              w_core_req;
    logic              w_pick_dbg;
    logic              w_issue;
    logic              w_iss_dbg;
    logic              w_iss_core;
    logic              w_iss_wr;
    logic              w_iss_rd;
    logic              w_done;
    logic              w_dbg_owns;
    logic              w_stall;

    // Arbitration: on a conflict the requester that did not win last time goes first.
    always_comb begin
        w_core_req = core_rd | core_wr;
        w_done     = (r_state == ST_WAIT) && (r_lat == LAT_W'(RD_LAT));
        if (dbg_req && w_core_req) begin
            w_pick_dbg = ~r_last_dbg;
        end else begin
            w_pick_dbg = dbg_req;
        end
        w_issue    = (r_state == ST_IDLE) && (w_core_req || dbg_req);
        w_iss_dbg  = w_issue && w_pick_dbg;
        w_iss_core = w_issue && !w_pick_dbg;
        w_iss_wr   = w_iss_dbg ? dbg_we : core_wr;
        w_iss_rd   = w_issue && !w_iss_wr;
        w_dbg_owns = w_iss_dbg || ((r_state == ST_WAIT) && r_owner_dbg);
        w_stall    = reset && w_core_req
                     && !(w_iss_core && core_wr)
                     && !(w_done && !r_owner_dbg);
    end

    // Outputs are forced low while reset is held, including the pass-through paths.
    always_comb begin
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wr_data  = '0;
        dbg_gnt      = 1'b0;
        dbg_rvalid   = 1'b0;
        dbg_rd_data  = '0;
        core_rd_data = '0;
        core_stall   = w_stall;
        busy         = (r_state == ST_WAIT);
        stall_cnt    = r_stall_cnt;
        if (reset) begin
            if (w_issue) begin
                mem_rd      = w_iss_rd;
                mem_wr      = w_issue && w_iss_wr;
                mem_addr    = w_iss_dbg ? dbg_addr : core_addr;
                mem_wr_data = w_iss_dbg ? dbg_wr_data : core_wr_data;
                dbg_gnt     = w_iss_dbg;
            end
            if (w_done) begin
                if (r_owner_dbg) begin
                    dbg_rvalid  = 1'b1;
                    dbg_rd_data = mem_rd_data;
                end else begin
                    core_rd_data = mem_rd_data;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat;
        w_owner_nxt = r_owner_dbg;
        w_last_nxt  = r_last_dbg;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_last_nxt = w_pick_dbg;
                end
                if (w_iss_rd) begin
                    w_state_nxt = ST_WAIT;
                    w_lat_nxt   = LAT_W'(1);
                    w_owner_nxt = w_pick_dbg;
                end
            end
            ST_WAIT: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                    w_lat_nxt   = '0;
                end else begin
                    w_lat_nxt = r_lat + LAT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_lat_nxt   = '0;
            end
        endcase
    end

    // Reset leaves last_grant at dbg so the core wins the first conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_lat       <= '0;
            r_owner_dbg <= 1'b0;
            r_last_dbg  <= 1'b1;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat       <= w_lat_nxt;
            r_owner_dbg <= w_owner_nxt;
            r_last_dbg  <= w_last_nxt;
            if (w_stall && w_dbg_owns && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with RD_LAT=1, one with RD_LAT=2,
// both fed the same stimulus; each step checks the instance it targets.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        core_rd;
    logic        core_wr;
    logic [8:0]  core_addr;
    logic [31:0] core_wr_data;
    logic        dbg_req;
    logic        dbg_we;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wr_data;
    logic [31:0] mem_rd_data;

    logic [31:0] a_core_rd_data, b_core_rd_data;
    logic        a_core_stall,   b_core_stall;
    logic        a_dbg_gnt,      b_dbg_gnt;
    logic        a_dbg_rvalid,   b_dbg_rvalid;
    logic [31:0] a_dbg_rd_data,  b_dbg_rd_data;
    logic        a_mem_rd,       b_mem_rd;
    logic        a_mem_wr,       b_mem_wr;
    logic [8:0]  a_mem_addr,     b_mem_addr;
    logic [31:0] a_mem_wr_data,  b_mem_wr_data;
    logic        a_busy,         b_busy;
    logic [15:0] a_stall_cnt,    b_stall_cnt;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .RD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wr_data(core_wr_data), .core_rd_data(a_core_rd_data), .core_stall(a_core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wr_data(dbg_wr_data),
        .dbg_gnt(a_dbg_gnt), .dbg_rvalid(a_dbg_rvalid), .dbg_rd_data(a_dbg_rd_data),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
        .mem_wr_data(a_mem_wr_data), .mem_rd_data(mem_rd_data),
        .busy(a_busy), .stall_cnt(a_stall_cnt)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .RD_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wr_data(core_wr_data), .core_rd_data(b_core_rd_data), .core_stall(b_core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wr_data(dbg_wr_data),
        .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid), .dbg_rd_data(b_dbg_rd_data),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
        .mem_wr_data(b_mem_wr_data), .mem_rd_data(mem_rd_data),
        .busy(b_busy), .stall_cnt(b_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        core_rd      = 1'b0;
        core_wr      = 1'b0;
        core_addr    = '0;
        core_wr_data = '0;
        dbg_req      = 1'b0;
        dbg_we       = 1'b0;
        dbg_addr     = '0;
        dbg_wr_data  = '0;
        mem_rd_data  = '0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        core_wr = 1'b1; core_addr = 9'h011; core_wr_data = 32'h55AA55AA;
        dbg_req = 1'b1; dbg_addr = 9'h022; mem_rd_data = 32'hFFFFFFFF;
        #1;
        chk("rst_mem_wr",     a_mem_wr, 0);
        chk("rst_mem_rd",     a_mem_rd, 0);
        chk("rst_mem_addr",   a_mem_addr, 0);
        chk("rst_mem_wdata",  a_mem_wr_data, 0);
        chk("rst_core_stall", a_core_stall, 0);
        chk("rst_dbg_gnt",    a_dbg_gnt, 0);
        chk("rst_busy",       a_busy, 0);
        chk("rst_stall_cnt",  a_stall_cnt, 0);

        next_cycle(); reset = 1'b1; clear_inputs();

        // Zero-stall core write
        next_cycle(); core_wr = 1'b1; core_addr = 9'h010; core_wr_data = 32'hDEADBEEF; #1;
        chk("cw_mem_wr",     a_mem_wr, 1);
        chk("cw_mem_rd",     a_mem_rd, 0);
        chk("cw_mem_addr",   a_mem_addr, 9'h010);
        chk("cw_mem_wdata",  a_mem_wr_data, 32'hDEADBEEF);
        chk("cw_core_stall", a_core_stall, 0);
        chk("cw_busy",       a_busy, 0);
        next_cycle(); clear_inputs(); #1;
        chk("cw_after_busy", a_busy, 0);
        chk("cw_after_wr",   a_mem_wr, 0);
        chk("idle_addr",     a_mem_addr, 0);

        // Core read with RD_LAT=2
        next_cycle(); core_rd = 1'b1; core_addr = 9'h020; #1;
        chk("l2_t0_stall", b_core_stall, 1);
        chk("l2_t0_rd",    b_mem_rd, 1);
        chk("l2_t0_addr",  b_mem_addr, 9'h020);
        next_cycle(); #1;
        chk("l2_t1_stall", b_core_stall, 1);
        chk("l2_t1_rd",    b_mem_rd, 0);
        chk("l2_t1_busy",  b_busy, 1);
        chk("l2_t1_rdata", b_core_rd_data, 0);
        next_cycle(); mem_rd_data = 32'h12345678; #1;
        chk("l2_t2_stall", b_core_stall, 0);
        chk("l2_t2_rdata", b_core_rd_data, 32'h12345678);
        chk("l2_t2_rd",    b_mem_rd, 0);
        chk("l2_t2_busy",  b_busy, 1);
        next_cycle(); clear_inputs(); #1;
        chk("l2_t3_busy",  b_busy, 0);
        chk("l2_t3_rdata", b_core_rd_data, 0);

        next_cycle(); reset = 1'b0; #1;
        next_cycle(); reset = 1'b1;

        // First conflict after reset: core wins; then dbg wins the second conflict
        next_cycle();
        core_rd = 1'b1; core_addr = 9'h030;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h0AA; #1;
        chk("c1_mem_rd",  a_mem_rd, 1);
        chk("c1_addr",    a_mem_addr, 9'h030);
        chk("c1_dbg_gnt", a_dbg_gnt, 0);
        chk("c1_stall",   a_core_stall, 1);
        next_cycle(); mem_rd_data = 32'h11111111; #1;
        chk("c1_done_stall", a_core_stall, 0);
        chk("c1_done_rdata", a_core_rd_data, 32'h11111111);
        chk("c1_done_gnt",   a_dbg_gnt, 0);
        chk("c1_done_rv",    a_dbg_rvalid, 0);
        next_cycle(); core_addr = 9'h040; mem_rd_data = 32'h0; #1;
        chk("c2_dbg_gnt", a_dbg_gnt, 1);
        chk("c2_mem_rd",  a_mem_rd, 1);
        chk("c2_addr",    a_mem_addr, 9'h0AA);
        chk("c2_stall",   a_core_stall, 1);
        chk("c2_cnt0",    a_stall_cnt, 0);
        next_cycle(); dbg_req = 1'b0; mem_rd_data = 32'h22222222; #1;
        chk("c2_rvalid", a_dbg_rvalid, 1);
        chk("c2_drdata", a_dbg_rd_data, 32'h22222222);
        chk("c2_stall_w", a_core_stall, 1);
        chk("c2_crdata", a_core_rd_data, 0);
        chk("c2_cnt1",   a_stall_cnt, 1);
        next_cycle(); mem_rd_data = 32'h0; #1;
        chk("c3_cnt2",    a_stall_cnt, 2);
        chk("c3_mem_rd",  a_mem_rd, 1);
        chk("c3_addr",    a_mem_addr, 9'h040);
        chk("c3_rvalid",  a_dbg_rvalid, 0);
        next_cycle(); mem_rd_data = 32'h33333333; #1;
        chk("c3_rdata",   a_core_rd_data, 32'h33333333);
        chk("c3_stall",   a_core_stall, 0);

        // Dbg write with core idle
        next_cycle(); clear_inputs();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h1FF; dbg_wr_data = 32'hCAFEF00D; #1;
        chk("dw_gnt",    a_dbg_gnt, 1);
        chk("dw_mem_wr", a_mem_wr, 1);
        chk("dw_addr",   a_mem_addr, 9'h1FF);
        chk("dw_wdata",  a_mem_wr_data, 32'hCAFEF00D);
        chk("dw_busy",   a_busy, 0);
        chk("dw_stall",  a_core_stall, 0);
        next_cycle(); clear_inputs(); #1;
        chk("dw_no_rv", a_dbg_rvalid, 0);
        chk("dw_cnt",   a_stall_cnt, 2);

        // Simultaneous core read and write: treated as a write
        next_cycle(); core_rd = 1'b1; core_wr = 1'b1; core_addr = 9'h077; core_wr_data = 32'h0BADF00D; #1;
        chk("rw_mem_wr", a_mem_wr, 1);
        chk("rw_mem_rd", a_mem_rd, 0);
        chk("rw_stall",  a_core_stall, 0);
        next_cycle(); clear_inputs(); #1;
        chk("rw_busy", a_busy, 0);

        // Reset during WAIT of a dbg read
        next_cycle(); dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h055; #1;
        chk("rw_dbg_gnt", a_dbg_gnt, 1);
        next_cycle(); dbg_req = 1'b0; mem_rd_data = 32'h44444444; reset = 1'b0; #1;
        chk("rm_rvalid", a_dbg_rvalid, 0);
        chk("rm_drdata", a_dbg_rd_data, 0);
        chk("rm_busy",   a_busy, 0);
        chk("rm_cnt",    a_stall_cnt, 0);
        next_cycle(); reset = 1'b1; mem_rd_data = 32'h0; #1;
        chk("rm_after_rv", a_dbg_rvalid, 0);
        next_cycle(); core_wr = 1'b1; core_addr = 9'h101; core_wr_data = 32'h01020304; #1;
        chk("rm_iss_wr",   a_mem_wr, 1);
        chk("rm_iss_addr", a_mem_addr, 9'h101);
        chk("rm_iss_cnt",  a_stall_cnt, 0);
        next_cycle(); clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
